// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule types, constants and rcon stepping
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // xtime in GF(2^8) with the AES reduction polynomial
  function automatic logic [7:0] rcon_next(input logic [7:0] rcon);
    return {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/key_expansion_if.sv
// rtl/key_expansion_if.sv - control and round-key read port bundle for key_expansion
interface key_expansion_if;
  import aes_pkg::*;

  logic       start;
  key_t       cipher_key;
  logic       busy;
  logic       done;
  logic [3:0] round_idx;
  key_t       round_key;

  modport master (
    output start, cipher_key, round_idx,
    input  busy, done, round_key
  );

  modport slave (
    input  start, cipher_key, round_idx,
    output busy, done, round_key
  );

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box, one byte
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 sits in the top byte, so the lookup index is 255 - i_byte (= ~i_byte)
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_bit_idx;

  assign w_bit_idx = {~i_byte, 3'b000};
  assign o_byte    = SBOX[w_bit_idx +: 8];

endmodule

// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - AES-128 key schedule, one round key per cycle into a register table
module key_expansion
  import aes_pkg::key_t;
  import aes_pkg::word_t;
  import aes_pkg::state_t;
  import aes_pkg::IDLE;
  import aes_pkg::EXPAND;
  import aes_pkg::READY;
  import aes_pkg::rcon_next;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic           Clk,
  input  logic           Reset,
  key_expansion_if.slave bus
);

  state_t     r_state;
  logic [3:0] r_counter;
  logic [7:0] r_rcon;
  logic       r_busy;
  logic       r_done;
  key_t       r_table [0:NR];

  key_t  w_prev;
  key_t  w_next;
  key_t  w_rd;
  word_t w_rot;
  word_t w_sub;
  word_t w_temp;
  word_t w_n0;
  word_t w_n1;
  word_t w_n2;
  word_t w_n3;

  // Previous round key is entry[counter-1]
  always_comb begin
    w_prev = '0;
    for (int i = 0; i <= NR; i++) begin
      if (4'(i) + 4'd1 == r_counter) w_prev = r_table[i];
    end
  end

  assign w_rot = {w_prev[23:0], w_prev[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  assign w_temp = w_sub ^ {r_rcon, 24'h0};
  assign w_n0   = w_prev[127:96] ^ w_temp;
  assign w_n1   = w_prev[95:64]  ^ w_n0;
  assign w_n2   = w_prev[63:32]  ^ w_n1;
  assign w_n3   = w_prev[31:0]   ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};

  always_comb begin
    w_rd = '0;
    for (int i = 0; i <= NR; i++) begin
      if (4'(i) == bus.round_idx) w_rd = r_table[i];
    end
  end

  assign bus.round_key = w_rd;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_counter <= '0;
      r_rcon    <= 8'h01;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i <= NR; i++) r_table[i] <= '0;
    end else begin
      case (r_state)
        IDLE, READY: begin
          if (bus.start) begin
            r_table[0] <= bus.cipher_key;
            r_rcon     <= 8'h01;
            r_counter  <= 4'd1;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= NR; i++) begin
            if (4'(i) == r_counter) r_table[i] <= w_next;
          end
          r_rcon    <= rcon_next(r_rcon);
          r_counter <= r_counter + 4'd1;
          if (r_counter == 4'(NR)) begin
            r_state <= READY;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_expansion.sv
// tb/tb_key_expansion.sv - scoreboard bench for key_expansion using FIPS-197 vectors
module tb_key_expansion;
  import aes_pkg::*;

  localparam key_t KA    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam key_t KA_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam key_t KA_R2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam key_t KA_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam key_t KC    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam key_t KC_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam key_t KC_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic Clk = 1'b0;
  logic Reset;

  key_expansion_if bus ();

  key_expansion dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string name;
    logic  busy;
    logic  done;
    logic  key_en;
    key_t  key;
  } exp_t;

  exp_t sb_q[$];
  logic chk_req = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(negedge Clk) begin
    if (chk_req) begin
      exp_t e;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor: scoreboard empty, got busy=%b done=%b", bus.busy, bus.done);
      end else begin
        e = sb_q.pop_front();
        if (bus.busy !== e.busy || bus.done !== e.done ||
            (e.key_en && bus.round_key !== e.key)) begin
          n_fail++;
          $display("FAIL %s: got busy=%b done=%b key=%h, expected busy=%b done=%b key=%h",
                   e.name, bus.busy, bus.done, bus.round_key, e.busy, e.done, e.key);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic b, input logic d,
                            input logic ke, input key_t k);
    exp_t e;
    e.name = name; e.busy = b; e.done = d; e.key_en = ke; e.key = k;
    sb_q.push_back(e);
    chk_req = 1'b1;
    @(negedge Clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic chk_key(input string name, input logic [3:0] idx, input key_t k);
    bus.round_idx = idx;
    expect_out(name, 1'b0, 1'b1, 1'b1, k);
  endtask

  // Start, then check busy/done on every cycle until the table completes
  task automatic run_expand(input string tag, input key_t k, input bit inject);
    bus.cipher_key = k;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.cipher_key = ~k;
    for (int c = 0; c < 10; c++) begin
      expect_out($sformatf("%s_busy%0d", tag, c), 1'b1, 1'b0, 1'b0, '0);
      if (inject && c == 4) begin
        bus.cipher_key = KC;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
      end else begin
        tick();
      end
    end
    expect_out($sformatf("%s_done", tag), 1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    bus.start = 1'b0;
    bus.cipher_key = '0;
    bus.round_idx = 4'd0;
    expect_out("reset_idx0", 1'b0, 1'b0, 1'b1, '0);
    bus.round_idx = 4'd10;
    expect_out("reset_idx10", 1'b0, 1'b0, 1'b1, '0);
    tick();
    Reset = 1'b0;
    tick();

    run_expand("ka", KA, 1'b0);
    chk_key("ka_r0", 4'd0, KA);
    chk_key("ka_r1", 4'd1, KA_R1);
    chk_key("ka_r2", 4'd2, KA_R2);
    chk_key("ka_r10", 4'd10, KA_R10);
    for (int i = 11; i <= 15; i++) chk_key($sformatf("ka_oob%0d", i), 4'(i), '0);

    run_expand("inj", KA, 1'b1);
    chk_key("inj_r0", 4'd0, KA);
    chk_key("inj_r1", 4'd1, KA_R1);
    chk_key("inj_r10", 4'd10, KA_R10);

    bus.cipher_key = KC;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    Reset = 1'b1;
    bus.round_idx = 4'd0;
    expect_out("rst_mid_idx0", 1'b0, 1'b0, 1'b1, '0);
    bus.round_idx = 4'd1;
    expect_out("rst_mid_idx1", 1'b0, 1'b0, 1'b1, '0);
    tick();
    Reset = 1'b0;
    tick();
    tick();
    expect_out("rst_idle_hold", 1'b0, 1'b0, 1'b0, '0);

    run_expand("post_rst", KA, 1'b0);
    chk_key("post_rst_r1", 4'd1, KA_R1);
    chk_key("post_rst_r10", 4'd10, KA_R10);

    run_expand("kc", KC, 1'b0);
    chk_key("kc_r0", 4'd0, KC);
    chk_key("kc_r1", 4'd1, KC_R1);
    chk_key("kc_r10", 4'd10, KC_R10);

    for (int w = 0; w < 20 && sb_q.size() != 0; w++) tick();
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
